// File: rtl/weight_rom_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weight_rom_stream_ctrl
// Purpose  : Streams the contents of one registered on-chip weight ROM as a
//            valid/ready beat stream. The whole ROM is replayed num_passes
//            times per start command, in address order. An output FIFO
//            absorbs the ROM read latency, so consumer back-pressure never
//            drops or repeats a word.
// Revision : 1.0 - initial release
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle command pulse, sampled only while idle
//   num_passes      : pass count, latched when start is accepted
//   busy, done      : command in progress / one-cycle completion pulse
//   rom_addr/rom_ce : ROM read address and clock enable
//   rom_q           : ROM read data, valid READ_LATENCY cycles after the address
//   data_out*       : weight beat stream (valid/ready)
//
// Build option
//   WEIGHT_STREAM_LAST_EN : adds data_out_last, which marks the beat carrying
//                           ROM address DEPTH-1 of every pass.
// ============================================================================
module weight_rom_stream_ctrl #(
  parameter int DATA_WIDTH   = 128,
  parameter int DEPTH        = 2304,
  parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1,
  parameter int READ_LATENCY = 2,
  parameter int PASS_WIDTH   = 16,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
`ifdef WEIGHT_STREAM_LAST_EN
  ,
  output logic                  data_out_last
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_W-1:0]      C_PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0]      C_FIFO_LIMIT = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q,    state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
  logic [PASS_WIDTH-1:0]   pass_cnt_q, pass_cnt_d;
  logic [PASS_WIDTH-1:0]   passes_q,   passes_d;
  logic [READ_LATENCY-1:0] issue_sr_q, issue_sr_d;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]        count_q,    count_d;

`ifdef WEIGHT_STREAM_LAST_EN
  logic [READ_LATENCY-1:0] tag_sr_q,   tag_sr_d;
  logic [FIFO_DEPTH-1:0]   last_mem_q, last_mem_d;
`endif

  logic [OCC_W-1:0] w_inflight;
  logic [OCC_W-1:0] w_occ;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic             w_addr_wrap;
  logic             w_last_issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads in the ROM pipeline count against FIFO space, so every word that
  // lands on rom_q already has a free slot reserved for it.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + OCC_W'(issue_sr_q[i]);
    end
  end

  assign w_occ        = OCC_W'(count_q) + w_inflight;
  assign w_issue      = (state_q == S_STREAM) && (w_occ < C_FIFO_LIMIT);
  assign w_push       = issue_sr_q[READ_LATENCY-1];
  assign w_valid      = (count_q != '0);
  assign w_pop        = w_valid && data_out_ready;
  assign w_addr_wrap  = (addr_q == C_LAST_ADDR);
  assign w_last_issue = w_issue && w_addr_wrap &&
                        ((pass_cnt_q + PASS_WIDTH'(1)) == passes_q);

  // Control: FSM, address and pass sequencing
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pass_cnt_d = pass_cnt_q;
    passes_d   = passes_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = '0;
          pass_cnt_d = '0;
          if (num_passes != '0) begin
            passes_d = num_passes;
            state_d  = S_STREAM;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_STREAM: begin
        if (w_issue) begin
          if (w_addr_wrap) begin
            addr_d     = '0;
            pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
          end else begin
            addr_d     = addr_q + ADDR_WIDTH'(1);
          end
        end
        if (w_last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((w_inflight == '0) && (count_q == '0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // In-flight tracker: the tail flag marks the cycle rom_q holds a wanted word
  always_comb begin
    issue_sr_d    = '0;
    issue_sr_d[0] = w_issue;
    for (int i = 1; i < READ_LATENCY; i++) begin
      issue_sr_d[i] = issue_sr_q[i-1];
    end
  end

`ifdef WEIGHT_STREAM_LAST_EN
  always_comb begin
    tag_sr_d    = '0;
    tag_sr_d[0] = w_issue && w_addr_wrap;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_sr_d[i] = tag_sr_q[i-1];
    end
  end
`endif

  // Output FIFO
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
`ifdef WEIGHT_STREAM_LAST_EN
    last_mem_d = last_mem_q;
`endif
    if (w_push) begin
      fifo_mem_d[wr_ptr_q] = rom_q;
`ifdef WEIGHT_STREAM_LAST_EN
      last_mem_d[wr_ptr_q] = tag_sr_q[READ_LATENCY-1];
`endif
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (w_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      pass_cnt_q <= '0;
      passes_q   <= '0;
      issue_sr_q <= '0;
      fifo_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef WEIGHT_STREAM_LAST_EN
      tag_sr_q   <= '0;
      last_mem_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pass_cnt_q <= pass_cnt_d;
      passes_q   <= passes_d;
      issue_sr_q <= issue_sr_d;
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef WEIGHT_STREAM_LAST_EN
      tag_sr_q   <= tag_sr_d;
      last_mem_q <= last_mem_d;
`endif
    end
  end

  // Outputs are pure decodes of registered state
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign rom_ce         = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign rom_addr       = addr_q;
  assign data_out       = fifo_mem_q[rd_ptr_q];
  assign data_out_valid = w_valid;
`ifdef WEIGHT_STREAM_LAST_EN
  // Storage is not cleared on pop, so qualify the tag with valid
  assign data_out_last  = w_valid && last_mem_q[rd_ptr_q];
`endif

endmodule
`default_nettype wire

// File: doc/weight_rom_stream_ctrl.md
Name: weight_rom_stream_ctrl

Overview:
- Sequences one on-chip weight ROM (registered, fixed READ_LATENCY, clock-enable gated) into a valid/ready weight stream for a linear/matmul consumer.
- Replays the full ROM contents NUM_PASSES times per start command, once per input row tile.
- Absorbs ROM read latency with an output buffer, so consumer back-pressure never loses or duplicates a word.
- Sits between the *_weight ROM wrapper and the dataflow weight input of the layer.

Parameters:
- DATA_WIDTH, 128: width of one ROM word, which is one output beat.
- DEPTH, 2304: number of ROM words per pass.
- ADDR_WIDTH, $clog2(DEPTH)+1: ROM address width.
- READ_LATENCY, 2: cycles from address cycle to data visible on rom_q.
- PASS_WIDTH, 16: width of num_passes.
- FIFO_DEPTH, READ_LATENCY+2: output buffer entries. Must be at least READ_LATENCY+2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: one-cycle command pulse, sampled only in IDLE.
- num_passes, input, PASS_WIDTH: pass count, latched on an accepted start.
- busy, output, 1: high from the cycle after start is accepted until the cycle done is asserted (inclusive).
- done, output, 1: one-cycle completion pulse.
- rom_addr, output, ADDR_WIDTH: ROM read address.
- rom_ce, output, 1: ROM clock enable.
- rom_q, input, DATA_WIDTH: ROM read data.
- data_out, output, DATA_WIDTH: weight beat.
- data_out_valid, output, 1: beat valid.
- data_out_ready, input, 1: consumer ready.

Behaviour:
- Clock and reset: clock clk; reset rst, synchronous, active-high.
- Reset values: busy=0, done=0, rom_addr=0, rom_ce=0, data_out_valid=0, data_out=0. FIFO, in-flight tracker, address counter and pass counter all cleared.
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE: start=1 with num_passes>0 → latch num_passes, go to STREAM. start=1 with num_passes=0 → go to DONE; no ROM reads issued.
  - STREAM → DRAIN: on the cycle the last address of the last pass is issued.
  - DRAIN → DONE: when in-flight count is 0 and the FIFO is empty.
  - DONE → IDLE: after exactly one cycle, during which done=1.
- start outside IDLE is ignored.
- rom_ce=1 in STREAM and DRAIN, so the ROM pipeline free-runs; rom_ce=0 otherwise.
- Issue condition: a read is issued in a cycle when state is STREAM and (FIFO occupancy + in-flight) < FIFO_DEPTH.
- In-flight tracking: a READ_LATENCY-deep shift register of issue flags. When its tail flag is 1, the FIFO captures rom_q.
  - This credit scheme guarantees the FIFO never overflows.
  - Ignore rom_q when the tail flag is 0.
- Address sequencing: on each issue, rom_addr advances. When rom_addr reaches DEPTH-1 it wraps to 0 and the pass counter increments. No gap between passes.
- rom_addr holds its value when no read is issued.
- Output handshake:
  - data_out is the FIFO head (first-word-fall-through from registered storage); data_out_valid = FIFO not empty.
  - Pop on valid && ready.
  - data_out is stable while valid=1 and ready=0.
  - Push and pop in the same cycle are both honoured, and occupancy is unchanged.
- Latency: start accepted at the edge ending cycle 0 → addr 0 issued in cycle 1 → with READ_LATENCY=2, first data_out_valid in cycle 4.
- Throughput: with ready held 1, one beat per cycle sustained, including across pass boundaries.
- Beat count: exactly DEPTH*num_passes beats per command, in address order.
- Reset mid-operation: returns to IDLE next cycle with all reset values. In-flight ROM data is discarded and no done pulse is produced.

Optional Feature:
- Macro: WEIGHT_STREAM_LAST_EN.
- Defined:
  - Adds output port data_out_last (1 bit, reset 0), asserted together with data_out_valid on the beat carrying ROM address DEPTH-1 of each pass.
  - The tag is carried through the in-flight shift register and the FIFO alongside the data.
- Undefined: no port, no extra storage; behaviour otherwise identical.

Test Plan:
- DEPTH=8, ROM word i = i, num_passes=1, ready always 1 → data_out 0..7 on 8 consecutive cycles, first beat in cycle 4 after start. done pulses once after the last beat; busy falls the cycle after done.
- DEPTH=8, num_passes=3, ready always 1 → 24 contiguous beats 0..7,0..7,0..7 with no bubble at the wraps. With WEIGHT_STREAM_LAST_EN defined, data_out_last is high on the 3 beats with value 7.
- DEPTH=8, num_passes=2, ready random 50% → exactly 16 beats in order, none lost or duplicated. data_out is stable while stalled; FIFO occupancy + in-flight never exceeds FIFO_DEPTH (assertion).
- num_passes=0 → done pulses the cycle after DONE is entered; rom_ce stays 0; no valid beat. A second start pulse while busy → ignored, beat count unchanged.
- Hold ready=0 for 20 cycles after start → exactly FIFO_DEPTH words buffered and issue stops. Release ready → stream resumes at the correct next value.
- Assert rst in the middle of pass 2 → next cycle busy=0, valid=0, no done pulse. A new start → stream restarts at word 0.
